// File: rtl/multicycle_control_fsm_if.sv
// Control-unit bundle: instruction/flag/memory-ready inputs and datapath control outputs.
interface multicycle_control_fsm_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_en;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic [2:0] imm_src;
  logic       fault;
  logic [1:0] fault_cause;
  logic [3:0] state;

  modport slave (
    input  opcode, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_en, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src,
           fault, fault_cause, state
  );

  modport master (
    output opcode, zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_en, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src,
           fault, fault_cause, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32 control FSM: fetch/decode/execute/memory/writeback over a shared
// memory port, with a memory-stall timeout and a sticky FAULT state.
module multicycle_control_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int TIMEOUT       = 16
) (
  input logic               clk,
  input logic               reset,
  multicycle_control_fsm_if.slave bus
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
    S_ALUWB = 4'd8, S_BEQ = 4'd9, S_JAL = 4'd10, S_LUI = 4'd11, S_FAULT = 4'd12
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cause_q, cause_d;

  logic       rdy, in_wait, expire;
  logic       mem_req, mem_write, adr_src, ir_write, reg_write, pc_write, branch, fault;
  logic [1:0] src_a, src_b, alu_op, result_src;
  logic [2:0] imm_src;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    cnt_d      = '0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    fault      = 1'b0;
    src_a      = 2'b00;
    src_b      = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    rdy        = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
    in_wait    = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    expire     = (TIMEOUT > 0) && in_wait && !rdy && (cnt_q == TO_LAST);

    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        src_b      = 2'b10;
        result_src = 2'b10;
        ir_write   = rdy;
        pc_write   = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUI;
          default: begin
            state_d = S_FAULT;
            cause_d = 2'b01;
          end
        endcase
      end
      S_MEMADR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        state_d = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_EXECR: begin
        src_a   = 2'b10;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        src_a   = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        src_a    = 2'b01;
        src_b    = 2'b10;
        pc_write = 1'b1;
        state_d  = S_ALUWB;
      end
      S_LUI: begin
        src_a   = 2'b11;
        src_b   = 2'b01;
        state_d = S_ALUWB;
      end
      S_FAULT: fault = 1'b1;
      default: state_d = S_FETCH;
    endcase

    // Stall limit reached with memory still not ready; a ready on this cycle wins.
    if (expire) begin
      state_d = S_FAULT;
      cause_d = 2'b10;
    end
    if (in_wait && !rdy && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    case (bus.opcode)
      OP_SW:   imm_src = 3'b001;
      OP_BEQ:  imm_src = 3'b010;
      OP_JAL:  imm_src = 3'b011;
      OP_LUI:  imm_src = 3'b100;
      default: imm_src = 3'b000;
    endcase
  end

  assign bus.mem_req     = mem_req;
  assign bus.mem_write   = mem_write;
  assign bus.adr_src     = adr_src;
  assign bus.ir_write    = ir_write;
  assign bus.pc_en       = pc_write | (branch & bus.zero);
  assign bus.reg_write   = reg_write;
  assign bus.alu_src_a   = src_a;
  assign bus.alu_src_b   = src_b;
  assign bus.alu_op      = alu_op;
  assign bus.result_src  = result_src;
  assign bus.imm_src     = imm_src;
  assign bus.fault       = fault;
  assign bus.fault_cause = cause_q;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed scenarios plus randomized instruction
// streams, checked each cycle against an instruction-plan reference model.
module tb_multicycle_control_fsm;
  localparam int TO = 4;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BQ = 7'b1100011, JL = 7'b1101111, LU = 7'b0110111, BAD = 7'b1111111;

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_en, reg_write;
    logic [1:0] a, b, op, rs;
    logic [2:0] imm;
    logic       fault;
    logic [1:0] cause;
    logic [3:0] st;
  } outs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  multicycle_control_fsm_if bus();

  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b1), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: current step number, stall run length, fault cause and the
  // remaining list of steps planned for the instruction being executed.
  int m_st = 0, m_stall = 0, m_cause = 0;
  int plan[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    if (op == SW) return 3'd1;
    if (op == BQ) return 3'd2;
    if (op == JL) return 3'd3;
    if (op == LU) return 3'd4;
    return 3'd0;
  endfunction

  function automatic outs_t exp_outs(input int st, input bit rdy, input bit z, input logic [6:0] op);
    outs_t o;
    o = '0;
    o.st    = 4'(st);
    o.imm   = imm_of(op);
    o.cause = 2'(m_cause);
    case (st)
      0:  begin o.mem_req = 1; o.b = 2; o.rs = 2; o.ir_write = rdy; o.pc_en = rdy; end
      1:  begin o.a = 1; o.b = 1; end
      2:  begin o.a = 2; o.b = 1; end
      3:  begin o.mem_req = 1; o.adr_src = 1; end
      4:  begin o.rs = 1; o.reg_write = 1; end
      5:  begin o.mem_req = 1; o.mem_write = 1; o.adr_src = 1; end
      6:  begin o.a = 2; o.op = 2; end
      7:  begin o.a = 2; o.b = 1; o.op = 2; end
      8:  o.reg_write = 1;
      9:  begin o.a = 2; o.op = 1; o.pc_en = z; end
      10: begin o.a = 1; o.b = 2; o.pc_en = 1; end
      11: begin o.a = 3; o.b = 1; end
      default: o.fault = 1;
    endcase
    return o;
  endfunction

  task automatic m_reset();
    m_st = 0; m_stall = 0; m_cause = 0;
    plan.delete();
  endtask

  task automatic m_advance(input logic [6:0] op, input bit rdy);
    if (m_st == 12) return;
    if (m_st == 0 || m_st == 3 || m_st == 5) begin
      if (!rdy) begin
        if (m_stall == TO - 1) begin
          m_st = 12; m_cause = 2; m_stall = 0; plan.delete();
        end else m_stall++;
        return;
      end
      m_stall = 0;
    end
    if (m_st == 0) begin
      m_st = 1;
      return;
    end
    if (m_st == 1) begin
      case (op)
        LW:      plan = '{2, 3, 4};
        SW:      plan = '{2, 5};
        RT:      plan = '{6, 8};
        IT:      plan = '{7, 8};
        BQ:      plan = '{9};
        JL:      plan = '{10, 8};
        LU:      plan = '{11, 8};
        default: begin m_st = 12; m_cause = 1; return; end
      endcase
    end
    m_st = (plan.size() > 0) ? plan.pop_front() : 0;
  endtask

  // One clock: drive at the falling edge, compare 1 ns later, advance the model.
  task automatic step(input logic [6:0] op, input bit rdy, input bit z);
    outs_t e, g;
    @(negedge clk);
    reset = 1'b0;
    bus.opcode = op; bus.mem_ready = rdy; bus.zero = z;
    #1;
    e = exp_outs(m_st, rdy, z, op);
    g = '{bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_en, bus.reg_write,
          bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src, bus.imm_src,
          bus.fault, bus.fault_cause, bus.state};
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL cycle outputs: got %h expected %h (t=%0t)", g, e, $time);
    end
    m_advance(op, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_fault", 32'(bus.fault), 32'd0);
    chk("reset_cause", 32'(bus.fault_cause), 32'd0);
    m_reset();
  endtask

  initial begin
    int fault_cycles;
    int burst;
    logic [6:0] op;
    logic [6:0] ops[7];
    bit rdy;
    ops = '{LW, SW, RT, IT, BQ, JL, LU};
    bus.opcode = LW; bus.mem_ready = 1'b0; bus.zero = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // lw, memory always ready: 0,1,2,3,4 then FETCH
    for (int i = 0; i < 5; i++) begin
      step(LW, 1, 0);
      chk("lw_state", 32'(bus.state), 32'(i));
      if (i == 1) chk("lw_imm", 32'(bus.imm_src), 32'd0);
      if (i == 4) chk("lw_memwb", {bus.reg_write, bus.result_src}, 32'b101);
      if (i == 3) chk("lw_noreg", 32'(bus.reg_write), 32'd0);
    end

    // sw with three stall cycles in MEMWRITE
    step(SW, 1, 0); chk("sw_fetch", 32'(bus.state), 32'd0);
    step(SW, 1, 0); step(SW, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(SW, i == 3, 0);
      chk("sw_write", {bus.state, bus.mem_req, bus.mem_write}, {4'd5, 2'b11});
    end

    // beq taken then not taken
    step(BQ, 1, 0); chk("beq_fetch_pc", {bus.state, bus.pc_en}, {4'd0, 1'b1});
    step(BQ, 1, 0);
    step(BQ, 1, 1); chk("beq_taken", {bus.state, bus.pc_en}, {4'd9, 1'b1});
    step(BQ, 1, 0); chk("beq_fetch_pc2", 32'(bus.pc_en), 32'd1);
    step(BQ, 1, 0);
    step(BQ, 1, 0); chk("beq_not_taken", {bus.state, bus.pc_en}, {4'd9, 1'b0});

    // jal and lui
    step(JL, 1, 0); step(JL, 1, 0); chk("jal_decode", 32'(bus.state), 32'd1);
    step(JL, 1, 0); chk("jal_state", {bus.state, bus.pc_en, bus.imm_src}, {4'd10, 1'b1, 3'd3});
    step(JL, 1, 0); chk("jal_wb", {bus.state, bus.reg_write}, {4'd8, 1'b1});
    step(LU, 1, 0); step(LU, 1, 0);
    step(LU, 1, 0); chk("lui_state", {bus.state, bus.alu_src_a, bus.imm_src}, {4'd11, 2'b11, 3'd4});
    step(LU, 1, 0); chk("lui_wb", 32'(bus.state), 32'd8);

    // illegal opcode -> sticky FAULT, cause 01
    step(BAD, 1, 0); step(BAD, 1, 0); chk("bad_decode", 32'(bus.state), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(BAD, 1, 1);
      chk("bad_fault", {bus.state, bus.fault, bus.fault_cause}, {4'd12, 1'b1, 2'b01});
      chk("bad_enables", {bus.mem_req, bus.mem_write, bus.ir_write, bus.pc_en, bus.reg_write}, 32'd0);
    end
    do_reset();

    // four stalled FETCH cycles -> FAULT cause 10
    for (int i = 0; i < 4; i++) begin
      step(LW, 0, 0); chk("to_stall", 32'(bus.state), 32'd0);
    end
    step(LW, 0, 0); chk("to_fault", {bus.state, bus.fault_cause}, {4'd12, 2'b10});
    do_reset();
    // ready on the fourth cycle wins over the timeout
    for (int i = 0; i < 4; i++) step(LW, i == 3, 0);
    step(LW, 1, 0); chk("to_rdy_wins", {bus.state, bus.fault}, {4'd1, 1'b0});

    // randomized instruction stream
    op = LW; burst = 0; fault_cycles = 0;
    for (int n = 0; n < 4000; n++) begin
      if (m_st == 12 && ++fault_cycles > 2) begin
        do_reset();
        fault_cycles = 0;
      end
      if (m_st == 0)
        op = ($urandom_range(0, 11) == 0) ? 7'($urandom_range(0, 127)) : ops[$urandom_range(0, 6)];
      if (burst > 0) begin
        rdy = 0; burst--;
      end else if ($urandom_range(0, 24) == 0) begin
        rdy = 0; burst = $urandom_range(1, 5);
      end else rdy = ($urandom_range(0, 3) != 0);
      step(op, rdy, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
